permutation_sequencer: RTL and testbench
========================================

# permutation_sequencer

Sequential controller for the ASCON permutation. It holds the 320-bit state register and a round counter, and applies one round per clock (constant addition, then substitution layer, then diffusion layer) for either p^a (12 rounds) or p^b (6 rounds). The mode engine above it uses a start/done handshake.

## Interface
Parameters:
- none; round counts are fixed by ascon_pack constants (ROUNDS_A = 12, ROUNDS_B = 6)

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous, active-low reset
- start_i  in  1  request a permutation; sampled only in IDLE or DONE
- mode_i  in  1  0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i
- state_i  in  type_state  state loaded on an accepted start
- state_o  out  type_state  state register contents
- round_o  out  4  current round index (0..11); drives constant selection
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: state register = 0, round_o = 0, busy_o = 0, done_o = 0.
- IDLE:
  - start_i=1: load the state register from state_i; round_o = 0 if mode_i=0, else 6; go to RUN.
  - start_i=0: hold.
- RUN, each edge:
  - Update: state register <= pL(pS(pC(state register, RC[round_o]))).
  - RC[i] = 8'hF0 − i·8'h0F, XORed into the low byte of word 2 (RC[0] = F0, RC[6] = 96, RC[11] = 4B).
  - If round_o = 11: go to DONE and leave round_o at 11. Otherwise round_o increments by 1.
  - The round counter never wraps.
- DONE: done_o = 1 for exactly this one cycle.
  - start_i=1: same load as from IDLE, go directly to RUN (back-to-back permutations).
  - start_i=0: go to IDLE.
- IDLE also holds the result: state_o keeps the final value until the next accepted start.
- start_i in RUN is ignored. Neither mode_i nor state_i is re-sampled during RUN.
- mode_i selects the first round only. p^b is rounds 6..11 of p^a, as the ASCON spec defines.
- Reset asserted mid-RUN: immediate return to IDLE with reset values. The partial state is discarded.

## Timing
- Accepted start at edge E0 loads the register; state_o = state_i after E0.
- p^a:
  - Rounds are applied at edges E1..E12.
  - done_o is high in the cycle after E12, and state_o holds the final state during that cycle.
- p^b:
  - Rounds are applied at edges E1..E6.
  - done_o is high in the cycle after E6.
- busy_o is high from after E0 until the edge that enters DONE.
  - Deassertion is in the same cycle done_o rises.
- Latency from start_i to done_o: 13 cycles (p^a) or 7 cycles (p^b).
- Back-to-back throughput: one permutation per 13 cycles (p^a) or 7 cycles (p^b). No idle gap is needed.
- All outputs are registered or decoded from the FSM state. There is no combinational path from start_i to any output.

## Structure
- Shared in ascon_pack:
  - type_state
  - ROUNDS_A, ROUNDS_B
  - the RC function or table indexed by a 4-bit round
  - the FSM state enum type_perm_fsm
- Datapath: instantiate the existing constant_addition, substitution_layer and diffusion_layer in a combinational chain.
  - Control and the register stay in this module.
- One natural sub-module: round_counter.
  - Load value 0 or 6, enable, terminal flag at 11.

## Test plan
- Reset: drive resetb_i low with random inputs.
  - Expect state_o = 0, round_o = 0, busy_o = 0, done_o = 0.
- p^a with state_i words 80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a:
  - round_o steps 0→11.
  - done_o pulses exactly once, 13 cycles after start.
  - state_o matches 12 chained golden rounds from the standalone layer modules (RC F0..4B).
- p^b with the same input:
  - round_o steps 6→11 and done_o pulses 7 cycles after start.
  - The result equals golden rounds 6..11 (RC 96..4B).
- start_i held high through RUN, and mode_i toggled mid-RUN:
  - No restart, and the round count is unchanged.
  - start_i still high in DONE: back-to-back start with zero gap. The second load uses state_i as it is in DONE.
- resetb_i pulsed low at round_o = 5:
  - Immediate IDLE with all outputs at reset values.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation datapath and its sequencer.
// State is five 64-bit words; element [0] is x0, element [4] is x4.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 6;
    localparam logic [3:0] LAST_ROUND    = 4'(ROUNDS_A - 1);
    localparam logic [3:0] FIRST_ROUND_B = 4'(ROUNDS_A - ROUNDS_B);

    typedef enum logic [1:0] {
        PERM_IDLE = 2'd0,
        PERM_RUN  = 2'd1,
        PERM_DONE = 2'd2
    } type_perm_fsm;

    // RC[i] = F0 - i*0F, giving F0, E1, D2 ... 4B
    function automatic logic [7:0] round_constant(input logic [3:0] round);
        return 8'hF0 - 8'({4'd0, round} * 8'h0F);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_layers.sv
// ASCON round layers: constant addition, 5-bit S-box layer, linear diffusion layer.
// Purely combinational; no latency, no flow control.
// Chained by the sequencer as pL(pS(pC(x))).
module constant_addition
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);
    always_comb begin
        state_o          = state_i;
        state_o[2][7:0]  = state_i[2][7:0] ^ round_constant(round_i);
    end
endmodule

module substitution_layer
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    type_state x;
    type_state t;

    // Bit-sliced S-box: all 64 columns evaluated in parallel
    always_comb begin
        x    = state_i;
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t[0] = ~x[0] & x[1];
        t[1] = ~x[1] & x[2];
        t[2] = ~x[2] & x[3];
        t[3] = ~x[3] & x[4];
        t[4] = ~x[4] & x[0];
        x[0] = x[0] ^ t[1];
        x[1] = x[1] ^ t[2];
        x[2] = x[2] ^ t[3];
        x[3] = x[3] ^ t[4];
        x[4] = x[4] ^ t[0];
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        state_o = x;
    end
endmodule

module diffusion_layer
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    assign state_o[0] = state_i[0] ^ rotr(state_i[0], 19) ^ rotr(state_i[0], 28);
    assign state_o[1] = state_i[1] ^ rotr(state_i[1], 61) ^ rotr(state_i[1], 39);
    assign state_o[2] = state_i[2] ^ rotr(state_i[2],  1) ^ rotr(state_i[2],  6);
    assign state_o[3] = state_i[3] ^ rotr(state_i[3], 10) ^ rotr(state_i[3], 17);
    assign state_o[4] = state_i[4] ^ rotr(state_i[4],  7) ^ rotr(state_i[4], 41);
endmodule

// File: rtl/permutation_sequencer_round_counter.sv
// Round index for the permutation: loads 0 (p^a) or 6 (p^b), steps while enabled.
// One-cycle register latency; holds at the last round instead of wrapping.
// No flow control; the sequencer gates load and enable.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic       mode_i,
    input  logic       en_i,
    output logic [3:0] round_o,
    output logic       last_o
);
    assign last_o = (round_o == LAST_ROUND);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            round_o <= 4'd0;
        end else if (load_i) begin
            round_o <= mode_i ? FIRST_ROUND_B : 4'd0;
        end else if (en_i && !last_o) begin
            round_o <= round_o + 4'd1;
        end
    end
endmodule

// File: rtl/permutation_sequencer.sv
// Iterates one ASCON round per clock over a 320-bit state register for p^a or p^b.
// Latency start->done: 13 cycles (p^a), 7 cycles (p^b); back-to-back starts with no gap.
// start_i is honoured only in IDLE or DONE; it is ignored while busy_o is high.
module permutation_sequencer
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);
    type_perm_fsm fsm_q;
    type_perm_fsm fsm_d;
    logic         accept;
    logic         last_round;
    type_state    ca_dat;
    type_state    sl_dat;
    type_state    dl_dat;
    type_state    state_q;

    assign accept = start_i && (fsm_q != PERM_RUN);

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            PERM_IDLE: fsm_d = accept ? PERM_RUN : PERM_IDLE;
            PERM_RUN:  fsm_d = last_round ? PERM_DONE : PERM_RUN;
            PERM_DONE: fsm_d = accept ? PERM_RUN : PERM_IDLE;
            default:   fsm_d = PERM_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= PERM_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    round_counter u_round_counter (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .load_i   (accept),
        .mode_i   (mode_i),
        .en_i     (fsm_q == PERM_RUN),
        .round_o  (round_o),
        .last_o   (last_round)
    );

    constant_addition u_constant_addition (
        .state_i (state_q),
        .round_i (round_o),
        .state_o (ca_dat)
    );

    substitution_layer u_substitution_layer (
        .state_i (ca_dat),
        .state_o (sl_dat)
    );

    diffusion_layer u_diffusion_layer (
        .state_i (sl_dat),
        .state_o (dl_dat)
    );

    // Register only changes on a load or a round; IDLE and DONE hold the result
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
        end else if (accept) begin
            state_q <= state_i;
        end else if (fsm_q == PERM_RUN) begin
            state_q <= dl_dat;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == PERM_RUN);
    assign done_o  = (fsm_q == PERM_DONE);
endmodule

// File: tb/tb_permutation_sequencer.sv
// Bench for permutation_sequencer: table of permutations against a table-based S-box
// reference model, plus hand-written back-to-back and mid-run reset sequences.
module tb_permutation_sequencer;
    import ascon_pack::type_state;

    logic       clock_i;
    logic       resetb_i;
    logic       start_i;
    logic       mode_i;
    type_state  state_i;
    type_state  state_o;
    logic [3:0] round_o;
    logic       busy_o;
    logic       done_o;

    int n_cmp = 0;
    int n_err = 0;
    type_state sb_q[$];

    logic [4:0] sbox_tab [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    typedef struct {
        logic      mode;
        int        first;
        type_state st;
        type_state exp;
    } vec_t;
    vec_t vecs[4];

    permutation_sequencer dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .round_o  (round_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic logic [63:0] ror_ref(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic type_state round_ref(input type_state s, input int r);
        type_state  a;
        type_state  o;
        logic [4:0] idx;
        logic [4:0] sv;
        a = s;
        a[2][7:0] = a[2][7:0] ^ {4'(15 - r), 4'(r)};
        for (int b = 0; b < 64; b++) begin
            idx = {a[0][b], a[1][b], a[2][b], a[3][b], a[4][b]};
            sv  = sbox_tab[idx];
            o[0][b] = sv[4];
            o[1][b] = sv[3];
            o[2][b] = sv[2];
            o[3][b] = sv[1];
            o[4][b] = sv[0];
        end
        a[0] = o[0] ^ ror_ref(o[0], 19) ^ ror_ref(o[0], 28);
        a[1] = o[1] ^ ror_ref(o[1], 61) ^ ror_ref(o[1], 39);
        a[2] = o[2] ^ ror_ref(o[2], 1)  ^ ror_ref(o[2], 6);
        a[3] = o[3] ^ ror_ref(o[3], 10) ^ ror_ref(o[3], 17);
        a[4] = o[4] ^ ror_ref(o[4], 7)  ^ ror_ref(o[4], 41);
        return a;
    endfunction

    function automatic type_state perm_ref(input type_state s, input int first);
        type_state a;
        a = s;
        for (int r = first; r < 12; r++) a = round_ref(a, r);
        return a;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 320'(act), 320'(exp));
    endtask

    task automatic check_rnd(input string name, input logic [3:0] act, input logic [3:0] exp);
        check(name, 320'(act), 320'(exp));
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_o, '0);
        check_rnd({tag, "_round"}, round_o, 4'd0);
        check_bit({tag, "_busy"}, busy_o, 1'b0);
        check_bit({tag, "_done"}, done_o, 1'b0);
    endtask

    // Called #1 after the load edge; returns #1 after the edge that enters DONE
    task automatic run_check(input int first, input type_state loaded, input bit toggle);
        int        n;
        int        v;
        type_state exp;
        n = 12 - first;
        check("load_state", loaded, state_o);
        check_rnd("load_round", round_o, 4'(first));
        check_bit("load_busy", busy_o, 1'b1);
        check_bit("load_done", done_o, 1'b0);
        for (int k = 1; k <= n; k++) begin
            if (toggle) begin
                mode_i  = ~mode_i;
                state_i = rand_state();
            end
            step();
            v = (first + k > 11) ? 11 : first + k;
            check_rnd("run_round", round_o, 4'(v));
            check_bit("run_busy", busy_o, k < n);
            check_bit("run_done", done_o, k == n);
        end
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp = sb_q.pop_front();
            check("final_state", state_o, exp);
        end
    endtask

    initial begin
        type_state ref_st;
        type_state st2;
        ref_st[0] = 64'h80400c0600000000;
        ref_st[1] = 64'h8a55114d1cb6a9a2;
        ref_st[2] = 64'hbe263d4d7aecaa0f;
        ref_st[3] = 64'h4ed0ec0b98c529b7;
        ref_st[4] = 64'hc8cddf37bcd0284a;
        vecs[0] = '{mode: 1'b0, first: 0, st: ref_st, exp: perm_ref(ref_st, 0)};
        vecs[1] = '{mode: 1'b1, first: 6, st: ref_st, exp: perm_ref(ref_st, 6)};
        vecs[2].st = rand_state();
        vecs[2] = '{mode: 1'b0, first: 0, st: vecs[2].st, exp: perm_ref(vecs[2].st, 0)};
        vecs[3].st = rand_state();
        vecs[3] = '{mode: 1'b1, first: 6, st: vecs[3].st, exp: perm_ref(vecs[3].st, 6)};

        // Reset with random inputs toggling
        resetb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_i = 1'($urandom);
            mode_i  = 1'($urandom);
            state_i = rand_state();
            step();
            check_reset_outputs("reset");
        end
        start_i  = 1'b0;
        resetb_i = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");

        // Table of single permutations
        foreach (vecs[i]) begin
            start_i = 1'b1;
            mode_i  = vecs[i].mode;
            state_i = vecs[i].st;
            sb_q.push_back(vecs[i].exp);
            step();
            start_i = 1'b0;
            state_i = rand_state();
            mode_i  = ~mode_i;
            run_check(vecs[i].first, vecs[i].st, 1'b0);
            step();
            check_bit("idle_done", done_o, 1'b0);
            check_bit("idle_busy", busy_o, 1'b0);
            check("idle_hold", state_o, vecs[i].exp);
        end

        // Start held through RUN, mode toggled; back-to-back p^b from DONE
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = vecs[2].st;
        sb_q.push_back(vecs[2].exp);
        step();
        run_check(0, vecs[2].st, 1'b1);
        st2     = rand_state();
        mode_i  = 1'b1;
        state_i = st2;
        sb_q.push_back(perm_ref(st2, 6));
        step();
        start_i = 1'b0;
        run_check(6, st2, 1'b0);
        step();
        check_bit("b2b_end_done", done_o, 1'b0);
        check_bit("b2b_end_busy", busy_o, 1'b0);

        // Reset pulse at round 5, then a normal run
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = vecs[3].st;
        sb_q.push_back(perm_ref(vecs[3].st, 0));
        step();
        start_i = 1'b0;
        for (int c = 0; c < 20 && round_o != 4'd5; c++) step();
        check_rnd("reach_round5", round_o, 4'd5);
        check_bit("reach_round5_busy", busy_o, 1'b1);
        resetb_i = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        sb_q.delete();
        #2;
        resetb_i = 1'b1;
        step();
        check_reset_outputs("post_reset_idle");
        start_i = 1'b1;
        mode_i  = vecs[1].mode;
        state_i = vecs[1].st;
        sb_q.push_back(vecs[1].exp);
        step();
        start_i = 1'b0;
        run_check(vecs[1].first, vecs[1].st, 1'b0);
        step();
        check_bit("final_idle_done", done_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
